// File: rtl/sram_port_arbiter.sv
// Three-port arbiter (0 > 1 > 2, port-2 starvation override) that owns every async SRAM pin.
// Fixed two-cycle access per grant, oAck during ACCESS, oRdValid 2 cycles after oAck; requesters hold iReq until oAck.
module sram_port_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 16,
    parameter int STARVE_W     = 8
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [2:0]            iReq,
    input  logic [2:0]            iWe,
    input  logic [3*ADDR_W-1:0]   iAddr,
    input  logic [3*DATA_W-1:0]   iWdata,
    output logic [2:0]            oAck,
    output logic [2:0]            oRdValid,
    output logic [DATA_W-1:0]     oRdata,
    output logic                  oBusy,
    output logic [ADDR_W-1:0]     oSram_addr,
    inout  wire  [DATA_W-1:0]     ioSram_dq,
    output logic                  oSram_ce_n,
    output logic                  oSram_oe_n,
    output logic                  oSram_we_n,
    output logic                  oSram_lb_n,
    output logic                  oSram_ub_n
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [2:0]          ack_q, ack_d;
    logic [2:0]          rdvalid_q, rdvalid_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [1:0]          win;

    // Starved port 2 beats the fixed order only once its counter has saturated.
    always_comb begin
        if (iReq[2] && starve_q == STARVE_MAX) begin
            win = 2'd2;
        end else if (iReq[0]) begin
            win = 2'd0;
        end else if (iReq[1]) begin
            win = 2'd1;
        end else begin
            win = 2'd2;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        starve_d  = starve_q;
        ack_d     = '0;
        rdvalid_d = '0;
        if (state_q == ACCESS) begin
            state_d = HOLD;
        end else begin
            if (state_q == HOLD && !we_q) begin
                rdata_d            = ioSram_dq;
                rdvalid_d[owner_q] = 1'b1;
            end
            // Decision edge: ends IDLE or HOLD, so back-to-back grants never overlap.
            if (|iReq) begin
                state_d      = ACCESS;
                owner_d      = win;
                we_d         = iWe[win];
                addr_d       = iAddr[win*ADDR_W +: ADDR_W];
                wdata_d      = iWdata[win*DATA_W +: DATA_W];
                ack_d[win]   = 1'b1;
                if (win == 2'd2 || !iReq[2]) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
            end else begin
                state_d  = IDLE;
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
            rdvalid_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            rdvalid_q <= rdvalid_d;
            starve_q  <= starve_d;
        end
    end

    // Pins decode straight from state so a reset releases the bus immediately.
    assign oSram_ce_n = (state_q == IDLE);
    assign oSram_we_n = !(state_q == ACCESS && we_q);
    assign oSram_oe_n = (state_q == IDLE) || we_q;
    assign oSram_lb_n = 1'b0;
    assign oSram_ub_n = 1'b0;
    assign ioSram_dq  = (state_q != IDLE && we_q) ? wdata_q : 'z;
    assign oSram_addr = addr_q;
    assign oAck       = ack_q;
    assign oRdValid   = rdvalid_q;
    assign oRdata     = rdata_q;
    assign oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised bench for sram_port_arbiter: requester agents, an SRAM model and a transaction-schedule reference.
module tb_sram_port_arbiter;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int LIM = 16;

    logic            iClk = 1'b0;
    logic            iRst = 1'b0;
    logic [2:0]      iReq = '0;
    logic [2:0]      iWe = '0;
    logic [3*AW-1:0] iAddr = '0;
    logic [3*DW-1:0] iWdata = '0;
    logic [2:0]      oAck, oRdValid;
    logic [DW-1:0]   oRdata;
    logic            oBusy;
    logic [AW-1:0]   oSram_addr;
    wire  [DW-1:0]   sram_dq;
    logic            ce_n, oe_n, we_n, lb_n, ub_n;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .STARVE_W(8)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWe(iWe), .iAddr(iAddr), .iWdata(iWdata),
        .oAck(oAck), .oRdValid(oRdValid), .oRdata(oRdata), .oBusy(oBusy),
        .oSram_addr(oSram_addr), .ioSram_dq(sram_dq), .oSram_ce_n(ce_n), .oSram_oe_n(oe_n),
        .oSram_we_n(we_n), .oSram_lb_n(lb_n), .oSram_ub_n(ub_n)
    );

    always #5 iClk = ~iClk;

    // SRAM environment: 64 words, indexed by the low address bits.
    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] mmem [64];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? env_mem[oSram_addr[5:0]] : 'z;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            gap;
    } item_t;
    item_t items [3][64];
    int    head [3] = '{0, 0, 0};
    int    tail [3] = '{0, 0, 0};
    int    gapc [3] = '{0, 0, 0};
    bit    active [3] = '{0, 0, 0};

    typedef struct {
        logic [2:0]    ack, rdv;
        logic          busy, ce_n, we_n, oe_n, dq_chk, set_addr, set_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] dq, rd;
    } exp_t;
    exp_t          slot [8];
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_rdata = '0;
    int            starve = 0;
    int            next_dec = 0;

    int nerr = 0, nchk = 0, cyc = 0;
    int n_busy = 0, n_welow = 0, n_oelow = 0;
    logic [AW-1:0] welow_addr = '0;
    logic [DW-1:0] rdv_dat = '0;
    int ack_log[$], ack_cyc[$], rdv_cyc[$];

    function automatic logic [DW-1:0] iv(int i);
        return DW'(i * 313) ^ 16'hC3A5;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic exp_t dflt();
        exp_t e;
        e = '{default: '0};
        e.ce_n = 1'b1;
        e.we_n = 1'b1;
        e.oe_n = 1'b1;
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) slot[i] = dflt();
        m_addr   = '0;
        m_rdata  = '0;
        starve   = 0;
        next_dec = cyc + 1;
    endfunction

    // Arbitration rules applied to the inputs that will be sampled at the coming edge.
    function automatic void model_decide();
        int w, s1, s2, s3;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (cyc < next_dec) return;
        if (iReq == 3'b000) begin
            starve   = 0;
            next_dec = cyc + 1;
            return;
        end
        if (iReq[2] && starve == LIM) w = 2;
        else if (iReq[0]) w = 0;
        else if (iReq[1]) w = 1;
        else w = 2;
        starve = (w == 2 || !iReq[2]) ? 0 : ((starve < LIM) ? starve + 1 : LIM);
        we = iWe[w];
        a  = iAddr[w*AW +: AW];
        d  = iWdata[w*DW +: DW];
        s1 = (cyc + 1) % 8;
        s2 = (cyc + 2) % 8;
        s3 = (cyc + 3) % 8;
        slot[s1].ack[w]   = 1'b1;
        slot[s1].busy     = 1'b1;
        slot[s1].ce_n     = 1'b0;
        slot[s1].set_addr = 1'b1;
        slot[s1].addr     = a;
        slot[s1].we_n     = !we;
        slot[s1].oe_n     = we;
        slot[s1].dq_chk   = we;
        slot[s1].dq       = d;
        slot[s2].busy     = 1'b1;
        slot[s2].ce_n     = 1'b0;
        slot[s2].oe_n     = we;
        slot[s2].dq_chk   = we;
        slot[s2].dq       = d;
        if (we) begin
            mmem[a[5:0]] = d;
        end else begin
            slot[s3].rdv[w] = 1'b1;
            slot[s3].set_rd = 1'b1;
            slot[s3].rd     = mmem[a[5:0]];
        end
        next_dec = cyc + 2;
    endfunction

    function automatic void agents();
        for (int p = 0; p < 3; p++) begin
            if (active[p] && oAck[p]) begin
                active[p] = 0;
                head[p]++;
                iReq[p] = 1'b0;
            end
            if (!active[p] && head[p] < tail[p]) begin
                if (gapc[p] >= items[p][head[p] % 64].gap) begin
                    iReq[p]            = 1'b1;
                    iWe[p]             = items[p][head[p] % 64].we;
                    iAddr[p*AW +: AW]  = items[p][head[p] % 64].addr;
                    iWdata[p*DW +: DW] = items[p][head[p] % 64].wd;
                    active[p]          = 1;
                    gapc[p]            = 0;
                end else begin
                    gapc[p]++;
                end
            end
        end
    endfunction

    function automatic void compare();
        exp_t e;
        e = slot[cyc % 8];
        if (e.set_addr) m_addr = e.addr;
        if (e.set_rd) m_rdata = e.rd;
        chk("ack", 32'(oAck), 32'(e.ack));
        chk("rdvalid", 32'(oRdValid), 32'(e.rdv));
        chk("rdata", 32'(oRdata), 32'(m_rdata));
        chk("busy", 32'(oBusy), 32'(e.busy));
        chk("addr", 32'(oSram_addr), 32'(m_addr));
        chk("ce_n", 32'(ce_n), 32'(e.ce_n));
        chk("we_n", 32'(we_n), 32'(e.we_n));
        chk("oe_n", 32'(oe_n), 32'(e.oe_n));
        chk("lb_ub", 32'({lb_n, ub_n}), 32'd0);
        if (e.dq_chk) chk("dq", 32'(sram_dq), 32'(e.dq));
    endfunction

    always @(negedge iClk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 64; i++) begin
                env_mem[i] = iv(i);
                mmem[i]    = iv(i);
            end
        end
        if (!iRst) model_reset();
        else if (!ce_n && !we_n) env_mem[oSram_addr[5:0]] = sram_dq;
        compare();
        if (oBusy) n_busy++;
        if (!oe_n) n_oelow++;
        if (!we_n) begin
            n_welow++;
            welow_addr = oSram_addr;
        end
        for (int p = 0; p < 3; p++) begin
            if (oAck[p]) begin
                ack_log.push_back(p);
                ack_cyc.push_back(cyc);
            end
            if (oRdValid[p]) begin
                rdv_cyc.push_back(cyc);
                rdv_dat = oRdata;
            end
        end
        slot[cyc % 8] = dflt();
        if (iRst) begin
            agents();
            model_decide();
        end
        cyc++;
    end

    int ab, rb, busy0, wl0, ol0;

    function automatic int alog(int i);
        return (i < ack_log.size()) ? ack_log[i] : -1;
    endfunction
    function automatic int acyc(int i);
        return (i < ack_cyc.size()) ? ack_cyc[i] : -100;
    endfunction
    function automatic int rcyc(int i);
        return (i < rdv_cyc.size()) ? rdv_cyc[i] : -100;
    endfunction

    task automatic snap();
        ab    = ack_log.size();
        rb    = rdv_cyc.size();
        busy0 = n_busy;
        wl0   = n_welow;
        ol0   = n_oelow;
    endtask

    task automatic push(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int g);
        items[p][tail[p] % 64] = '{we, a, d, g};
        tail[p]++;
    endtask

    function automatic bit pending();
        for (int p = 0; p < 3; p++) if (head[p] < tail[p] || active[p]) return 1;
        return 0;
    endfunction

    task automatic wait_done(input int budget);
        int t = 0;
        while ((pending() || oBusy || oRdValid != 3'b000) && t < budget) begin
            @(negedge iClk);
            t++;
        end
        chk("drain_timeout", 32'(t >= budget), 32'd0);
        repeat (2) @(negedge iClk);
        @(posedge iClk);
    endtask

    function automatic logic [AW-1:0] raddr();
        return {14'($urandom), 1'b0, 5'($urandom)};
    endfunction

    initial begin
        int t, c2;
        repeat (3) @(posedge iClk);
        #1;
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_ce_n", 32'(ce_n), 32'd1);
        chk("rst_we_oe", 32'({we_n, oe_n}), 32'd3);
        chk("rst_rdata", 32'(oRdata), 32'd0);
        chk("rst_addr", 32'(oSram_addr), 32'd0);
        #1 iRst = 1'b1;

        // Single write from port 0.
        @(posedge iClk); snap();
        push(0, 1'b1, 20'h00010, 16'hABCD, 0);
        wait_done(50);
        chk("t1_nacks", 32'(ack_log.size() - ab), 32'd1);
        chk("t1_port", 32'(alog(ab)), 32'd0);
        chk("t1_welow", 32'(n_welow - wl0), 32'd1);
        chk("t1_weaddr", 32'(welow_addr), 32'h10);
        chk("t1_nrdv", 32'(rdv_cyc.size() - rb), 32'd0);

        // Read it back through port 1.
        snap();
        push(1, 1'b0, 20'h00010, 16'h0000, 0);
        wait_done(50);
        chk("t2_port", 32'(alog(ab)), 32'd1);
        chk("t2_nrdv", 32'(rdv_cyc.size() - rb), 32'd1);
        chk("t2_data", 32'(rdv_dat), 32'hABCD);
        chk("t2_lat", 32'(rcyc(rb) - acyc(ab)), 32'd2);
        chk("t2_oelow", 32'(n_oelow - ol0), 32'd2);
        chk("t2_welow", 32'(n_welow - wl0), 32'd0);

        // Simultaneous requests on all ports.
        snap();
        push(0, 1'b1, 20'h00001, 16'h1111, 0);
        push(1, 1'b0, 20'h00002, 16'h0000, 0);
        push(2, 1'b1, 20'h00003, 16'h3333, 0);
        wait_done(60);
        chk("t3_order0", 32'(alog(ab)), 32'd0);
        chk("t3_order1", 32'(alog(ab + 1)), 32'd1);
        chk("t3_order2", 32'(alog(ab + 2)), 32'd2);
        chk("t3_busy", 32'(n_busy - busy0), 32'd6);

        // Ports 0 and 2 held continuously: port 2 forced through every 17th decision.
        snap();
        for (int i = 0; i < 40; i++) push(0, i[0], raddr(), 16'($urandom), 0);
        for (int i = 0; i < 2; i++) push(2, 1'b0, raddr(), 16'h0000, 0);
        wait_done(400);
        chk("t4_nacks", 32'(ack_log.size() - ab), 32'd42);
        chk("t4_force1", 32'(alog(ab + 16)), 32'd2);
        chk("t4_force2", 32'(alog(ab + 33)), 32'd2);
        c2 = 0;
        for (int i = 0; i < 33; i++) if (i != 16 && alog(ab + i) == 2) c2++;
        chk("t4_early_p2", 32'(c2), 32'd0);

        // Port 1 back-to-back reads.
        snap();
        for (int i = 0; i < 4; i++) push(1, 1'b0, 20'h00010 + AW'(i), 16'h0000, 0);
        wait_done(60);
        for (int i = 1; i < 4; i++) chk("t5_spacing", 32'(acyc(ab + i) - acyc(ab + i - 1)), 32'd2);
        chk("t5_nrdv", 32'(rdv_cyc.size() - rb), 32'd4);
        chk("t5_span", 32'(rcyc(rb + 3) - acyc(ab)), 32'd8);
        chk("t5_busy", 32'(n_busy - busy0), 32'd8);

        // Random mixed traffic.
        snap();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 50; i++)
                push(p, 1'($urandom), raddr(), 16'($urandom), int'($urandom_range(0, 3 + 2 * p)));
        wait_done(3000);
        chk("rnd_nacks", 32'(ack_log.size() - ab), 32'd150);

        // Reset during the ACCESS cycle of a port 0 write.
        @(posedge iClk); snap();
        push(0, 1'b1, 20'h0003F, 16'h1234, 0);
        t = 0;
        do begin
            @(negedge iClk);
            t++;
        end while (!oAck[0] && t < 20);
        chk("t6_ack_timeout", 32'(t >= 20), 32'd0);
        #2 iRst = 1'b0;
        #1;
        chk("t6_we_n", 32'(we_n), 32'd1);
        chk("t6_ce_n", 32'(ce_n), 32'd1);
        chk("t6_busy", 32'(oBusy), 32'd0);
        chk("t6_ack", 32'(oAck), 32'd0);
        repeat (2) @(negedge iClk);
        @(posedge iClk);
        #2 iRst = 1'b1;
        snap();
        repeat (4) @(negedge iClk);
        @(posedge iClk);
        chk("t6_idle_acks", 32'(ack_log.size() - ab), 32'd0);
        chk("t6_idle_rdv", 32'(rdv_cyc.size() - rb), 32'd0);
        chk("t6_idle_busy", 32'(n_busy - busy0), 32'd0);

        snap();
        push(1, 1'b0, 20'h00010, 16'h0000, 0);
        wait_done(50);
        chk("t7_ack", 32'(alog(ab)), 32'd1);
        chk("t7_nrdv", 32'(rdv_cyc.size() - rb), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single DE2-115 external 16-bit async SRAM between three requesters: camera frame writer (port 0), VGA display reader (port 1) and image-processing engines such as the histogram/elimination pass (port 2).
Each granted request is one single-word read or write, sequenced as a fixed two-cycle SRAM access.
The block owns all SRAM control pins; requesters never drive the SRAM directly.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
STARVE_LIMIT, 16, consecutive lost decisions port 2 tolerates before a forced grant
STARVE_W, 8, width of starvation counter (must hold STARVE_LIMIT)

Ports:
iClk  in  1  clock
iRst  in  1  asynchronous reset, active-low
iReq  in  3  per-port request; held with iWe/iAddr/iWdata stable until oAck
iWe  in  3  per-port 1=write, 0=read
iAddr  in  3*ADDR_W  per-port address, port p at [p*ADDR_W +: ADDR_W]
iWdata  in  3*DATA_W  per-port write data, port p at [p*DATA_W +: DATA_W]
oAck  out  3  one-cycle pulse: request accepted
oRdValid  out  3  one-cycle pulse: oRdata valid for that port
oRdata  out  DATA_W  read data, shared, qualified by oRdValid
oBusy  out  1  1 while state != IDLE
oSram_addr  out  ADDR_W  SRAM address
ioSram_dq  inout  DATA_W  SRAM data; driven only during a write transaction, else high-Z
oSram_ce_n, oSram_oe_n, oSram_we_n, oSram_lb_n, oSram_ub_n  out  1 each  SRAM controls

Behaviour:
- Reset (iRst=0): state IDLE, oAck=0, oRdValid=0, oRdata=0, oBusy=0, oSram_addr=0, ce_n=1, oe_n=1, we_n=1, dq high-Z, starve counter=0. Reset is asynchronous and immediate. An in-flight access is dropped with no oRdValid and no further oAck.
- lb_n/ub_n are constant 0 (full-word accesses only).
- States: IDLE, ACCESS, HOLD. The arbitration decision is made at the clock edge that ends IDLE or HOLD.
- IDLE: ce_n=1, oe_n=1, we_n=1, dq Z. If any iReq bit is set at the edge: latch the winner's addr/we/wdata and owner, pulse oAck[winner] for the next cycle, go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle): ce_n=0, oSram_addr=latched address.
  - Write: we_n=0, oe_n=1, dq=wdata.
  - Read: we_n=1, oe_n=0, dq Z.
  - Next state: HOLD.
- HOLD (1 cycle): same address, we_n=1.
  - Write: dq still driven (data hold), oe_n=1.
  - Read: oe_n=0; ioSram_dq is captured into oRdata at the end-of-HOLD edge, and oRdValid[owner] pulses the following cycle.
  - At the end-of-HOLD edge, arbitrate again: a request present goes straight to ACCESS (back-to-back); otherwise go to IDLE.
- Timing: throughput is one transaction per 2 cycles. oRdValid follows the oAck pulse by exactly 2 cycles. A requester sees oAck during ACCESS and must update or deassert iReq by the next edge. The next decision samples at the end of HOLD, so it never double-grants.
- Priority: port 0 > port 1 > port 2 (fixed), with one override. If iReq[2]=1 and starve counter == STARVE_LIMIT at a decision, port 2 wins regardless.
- Starve counter:
  - +1 at each decision with iReq[2]=1 where port 2 loses.
  - Cleared when port 2 is granted or iReq[2]=0 at a decision.
  - Saturates at STARVE_LIMIT.
- oRdata holds its last captured value between reads; writes do not alter it.
- oSram_addr holds its last value in IDLE.
- Address/data widths pass through unmodified; no address wrap or arithmetic.

Test Plan:
- Port 0 write addr 0x00010 data 0xABCD, others idle -> oAck[0] one cycle; we_n=0 exactly one cycle with addr 0x00010; dq=0xABCD for 2 cycles then Z; oRdValid stays 0.
- Port 1 read addr 0x00010, SRAM model returns 0xABCD -> oAck[1], then 2 cycles later oRdValid[1]=1 for one cycle with oRdata=0xABCD; oe_n low for 2 cycles, we_n never low.
- iReq=3'b111 raised together, each port deasserts after its ack -> grants in order 0,1,2 at 2-cycle spacing; oBusy high 6 cycles.
- Ports 0 and 2 held continuously, STARVE_LIMIT=16 -> port 0 wins 16 decisions, port 2 granted on the 17th, then port 0 again 16 times (counter restarted).
- Port 1 issues 4 reads back-to-back (req held, address updated each ack) -> acks every 2 cycles, 4 oRdValid pulses within 9 cycles of first grant, no IDLE cycle in between.
- iRst pulled low during ACCESS of a port 0 write -> we_n=1 and dq Z immediately; no oAck/oRdValid afterwards; after release, block sits in IDLE until the next iReq.
